// File: rtl/lowpass_decimator_pkg.sv
// lowpass_pkg: shared widths and sample type for the lowpass decimator.
package lowpass_pkg;
    localparam int DATA_WIDTH     = 16;
    localparam int MAX_LOG2_RATIO = 7;
    localparam int ACC_WIDTH      = DATA_WIDTH + MAX_LOG2_RATIO;
    typedef logic signed [DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/lowpass_decimator_fifo.sv
// lpd_fifo: single-clock FIFO; a push on a full FIFO succeeds only alongside a pop.
module lpd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;
    assign empty_o = lvl_q == '0;
    assign full_o  = lvl_q == LW'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    assign level_o = lvl_q;
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din_i;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/lowpass_decimator.sv
// lowpass_decimator: keeps 1 of every 2^ratio_log2 samples into an output FIFO.
// Define LPD_AVG_EN to emit the group mean instead of the final sample.
module lowpass_decimator #(
    parameter int DATA_WIDTH = lowpass_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  in_sample,
    input  logic [2:0]                    ratio_log2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_sample,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    import lowpass_pkg::*;
    logic [MAX_LOG2_RATIO-1:0] phase_q, phase_d;
    logic [2:0]                rlog_q, rlog_d, rl;
    logic                      last, push, full, empty, overflow_q;
    logic [DATA_WIDTH-1:0]     dec, head;
    // The group's ratio is taken live on its first beat, then held in rlog_q.
    always_comb begin
        rl      = (phase_q == '0) ? ratio_log2 : rlog_q;
        last    = {1'b0, phase_q} == (8'd1 << rl) - 8'd1;
        phase_d = !in_valid ? phase_q : last ? '0 : phase_q + 1'b1;
        rlog_d  = (in_valid && phase_q == '0) ? ratio_log2 : rlog_q;
        push    = in_valid && last;
    end
`ifdef LPD_AVG_EN
    localparam int ACC_W = DATA_WIDTH + MAX_LOG2_RATIO;
    logic signed [ACC_W-1:0] acc_q, sum;
    always_comb begin
        sum = ACC_W'(in_sample) + ((phase_q == '0) ? '0 : acc_q);
        dec = DATA_WIDTH'(sum >>> rl);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else if (in_valid) acc_q <= sum;
    end
`else
    assign dec = in_sample;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= '0;
            rlog_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rlog_q  <= rlog_d;
            if (push && full && !out_ready) overflow_q <= 1'b1;
        end
    end
    lpd_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (out_ready),
        .din_i   (dec),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );
    assign out_valid  = !empty;
    assign out_sample = head;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_lowpass_decimator.sv
// tb_lowpass_decimator: table-driven directed check of the decimator and its output FIFO.
module tb_lowpass_decimator;
`ifdef LPD_AVG_EN
    localparam int A1 = 25, A2 = -10, B1 = 5, B2 = 9, C8 = 4, D4 = 3;
`else
    localparam int A1 = 40, A2 = -16, B1 = 6, B2 = 10, C8 = 8, D4 = 6;
`endif
    typedef struct {
        logic rst_n, v;
        int s;
        logic [2:0] r;
        logic rdy, ev;
        int es, el;
        logic eo;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [15:0] in_sample = '0;
    logic [2:0] ratio_log2 = '0;
    logic out_valid, overflow;
    logic signed [15:0] out_sample;
    logic [2:0] fifo_level;
    vec_t tbl [$];
    int total = 0, bad = 0;
    lowpass_decimator #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
        .ratio_log2(ratio_log2), .out_valid(out_valid), .out_ready(out_ready),
        .out_sample(out_sample), .fifo_level(fifo_level), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic row(input logic rs, input logic v, input int s, input int r, input logic rdy,
                       input logic ev, input int es, input int el, input logic eo);
        tbl.push_back('{rs, v, s, 3'(r), rdy, ev, es, el, eo});
    endtask
    task automatic chk(input string name, input int step, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, got, exp);
        end
    endtask
    task automatic apply(input logic rs, input logic v, input int s, input int r, input logic rdy);
        rst_n = rs; in_valid = v; in_sample = 16'(s); ratio_log2 = 3'(r); out_ready = rdy;
        @(posedge clk);
        #1;
    endtask
    initial begin
        row(0,1,99,0,1, 0,0,0,0);
        row(1,1,1,0,1, 1,1,1,0);   row(1,1,2,0,1, 1,2,1,0);   row(1,1,3,0,1, 1,3,1,0);
        row(1,0,0,0,1, 0,0,0,0);
        row(1,1,10,2,1, 0,0,0,0);  row(1,1,20,2,1, 0,0,0,0);  row(1,1,30,2,1, 0,0,0,0);
        row(1,1,40,2,1, 1,A1,1,0); row(1,1,-4,2,1, 0,0,0,0);  row(1,1,-8,2,1, 0,0,0,0);
        row(1,1,-12,2,1, 0,0,0,0); row(1,1,-16,2,1, 1,A2,1,0); row(1,0,0,0,1, 0,0,0,0);
        row(1,1,1,0,0, 1,1,1,0);   row(1,1,2,0,0, 1,1,2,0);   row(1,1,3,0,0, 1,1,3,0);
        row(1,1,4,0,0, 1,1,4,0);   row(1,1,5,0,0, 1,1,4,1);
        row(1,0,0,0,1, 1,2,3,1);   row(1,0,0,0,1, 1,3,2,1);   row(1,0,0,0,1, 1,4,1,1);
        row(1,0,0,0,1, 0,0,0,1);
        row(0,1,7,0,1, 0,0,0,0);
        row(1,1,11,0,0, 1,11,1,0); row(1,1,12,0,0, 1,11,2,0); row(1,1,13,0,0, 1,11,3,0);
        row(1,1,14,0,0, 1,11,4,0); row(1,1,15,0,1, 1,12,4,0);
        row(1,0,0,0,1, 1,13,3,0);  row(1,0,0,0,1, 1,14,2,0);  row(1,0,0,0,1, 1,15,1,0);
        row(1,0,0,0,1, 0,0,0,0);
        row(1,1,5,1,1, 0,0,0,0);   row(1,0,0,1,1, 0,0,0,0);   row(1,1,6,1,1, 1,B1,1,0);
        row(1,0,0,1,1, 0,0,0,0);   row(1,1,8,1,1, 0,0,0,0);   row(1,0,0,3,1, 0,0,0,0);
        row(1,1,10,3,1, 1,B2,1,0); row(1,0,0,3,1, 0,0,0,0);
        for (int i = 1; i <= 7; i++) row(1,1,i,3,1, 0,0,0,0);
        row(1,1,8,3,1, 1,C8,1,0);  row(1,0,0,3,1, 0,0,0,0);
        row(1,1,100,2,1, 0,0,0,0); row(1,1,100,2,1, 0,0,0,0); row(1,1,100,2,1, 0,0,0,0);
        row(0,1,100,2,1, 0,0,0,0);
        row(1,1,1,2,1, 0,0,0,0);   row(1,1,2,2,1, 0,0,0,0);   row(1,1,3,2,1, 0,0,0,0);
        row(1,1,6,2,1, 1,D4,1,0);
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            apply(tbl[i].rst_n, tbl[i].v, tbl[i].s, int'(tbl[i].r), tbl[i].rdy);
            chk("out_valid", i, int'(out_valid), int'(tbl[i].ev));
            chk("out_sample", i, int'(out_sample), tbl[i].es);
            chk("fifo_level", i, int'(fifo_level), tbl[i].el);
            chk("overflow", i, int'(overflow), int'(tbl[i].eo));
        end
        // Longest group: 128 beats of -3 must yield exactly one output on the last beat.
        for (int k = 1; k <= 127; k++) begin
            apply(1, 1, -3, 7, 1);
            chk("r128_idle", 1000 + k, int'(out_valid), 0);
        end
        apply(1, 1, -3, 7, 1);
        chk("r128_valid", 1128, int'(out_valid), 1);
        chk("r128_sample", 1128, int'(out_sample), -3);
        apply(1, 0, 0, 0, 1);
        chk("r128_drain", 1129, int'(fifo_level), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lowpass_decimator.md
LOWPASS_DECIMATOR -- requirements
Module: lowpass_decimator

Interface
REQ-001 Parameter: DATA_WIDTH, 16, sample width (signed two's complement).
REQ-002 Parameter: FIFO_DEPTH, 4, output buffer entries (power of two, >=2).
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  in_sample valid this cycle; no backpressure upstream.
REQ-006 Port: in_sample  input  DATA_WIDTH signed  filtered sample from lowpass filter output.
REQ-007 Port: ratio_log2  input  3  decimation factor R = 2^ratio_log2 (1..128).
REQ-008 Port: out_valid  output  1  FIFO head valid.
REQ-009 Port: out_ready  input  1  consumer accepts head when out_valid && out_ready.
REQ-010 Port: out_sample  output  DATA_WIDTH signed  FIFO head; 0 when empty.
REQ-011 Port: fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-012 Port: overflow  output  1  sticky: decimated sample dropped on full FIFO.

Function
REQ-013 Phase counter (7 bits) SHALL advance only on in_valid beats; idle cycles hold all state.
REQ-014 ratio_log2 SHALL be latched on the in_valid beat when phase==0; mid-group changes SHALL take effect at the next group.
REQ-015 Final beat of a group is the in_valid beat with phase==R-1; phase SHALL wrap to 0 on that beat.
REQ-016 R==1: every in_valid beat is a final beat.
REQ-017 On a final beat the decimated value SHALL be written to the FIFO at that clock edge; out_valid SHALL rise the following cycle (latency 1 cycle) if FIFO was empty.
REQ-018 Pop SHALL occur on out_valid && out_ready; FIFO order first-in first-out.
REQ-019 Push when full with no pop: new value SHALL be dropped, overflow set, FIFO contents unchanged.
REQ-020 Push and pop in same cycle when full: both SHALL succeed, level unchanged, overflow not set.
REQ-021 Push and pop in same cycle when level==1: head becomes new value next cycle, out_valid stays 1.
REQ-022 overflow SHALL remain 1 until reset.
REQ-023 fifo_level SHALL equal pushes minus pops since reset, saturating never beyond FIFO_DEPTH.

Reset
REQ-024 rst_n==0 at a clock edge SHALL clear: phase, latched ratio (R=1), accumulator, FIFO pointers, out_valid=0, out_sample=0, fifo_level=0, overflow=0.
REQ-025 Reset mid-group SHALL discard partial group; first in_valid after release starts a new group with phase 0.
REQ-026 in_valid asserted during reset SHALL be ignored.

Configuration
REQ-027 Macro LPD_AVG_EN defined: decimated value SHALL be mean of the R samples of the group: signed sum in accumulator of DATA_WIDTH+7 bits, arithmetic shift right by latched ratio_log2 (floor rounding); accumulator reloads with the first sample of each group.
REQ-028 Macro LPD_AVG_EN undefined: decimated value SHALL be the final-beat sample only; accumulator SHALL not be instantiated.

Structure
REQ-029 Package lowpass_pkg SHALL hold DATA_WIDTH default, MAX_LOG2_RATIO=7, ACC_WIDTH=DATA_WIDTH+MAX_LOG2_RATIO, and signed sample typedef sample_t.
REQ-030 FIFO SHALL be a separate sub-module lpd_fifo (synchronous, single clock, full/empty/level outputs); decimation control stays in lowpass_decimator.

Verification
REQ-031 ratio_log2=0, in_valid every cycle, samples 1,2,3; out_ready=1 -> out_sample 1,2,3 one cycle after each input, overflow=0.
REQ-032 ratio_log2=2, samples 10,20,30,40,-4,-8,-12,-16 -> LPD_AVG_EN: outputs 25 then -10; without: 40 then -16.
REQ-033 ratio_log2=0, out_ready=0, 5 valid samples, FIFO_DEPTH=4 -> level 4, fifth dropped, overflow=1; then out_ready=1 -> samples 1..4 drained, overflow stays 1.
REQ-034 Full FIFO, out_ready=1 and final beat same cycle -> level stays 4, overflow stays 0, new sample appears last.
REQ-035 ratio_log2=1, in_valid toggling every other cycle -> one output per 2 valid beats; ratio_log2 changed to 3 mid-group -> change applies from next group only.
REQ-036 rst_n low for 1 cycle after 3 of 4 group beats -> all outputs 0; next 4 valid samples form the first output.
